// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 encodings,
// FSM state type and a most-negative-value helper.
package mdu_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam int MAX_WIDTH = 128;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Two's-complement most-negative value for a given width, zero-extended.
  function automatic logic [MAX_WIDTH-1:0] most_neg(input int width);
    return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation, used both for operand magnitudes and
// for applying the result sign.
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply / restoring divide unit for RV32M funct3 ops.
// Define MDU_DIV_EN to build the divider; otherwise ops 1xx return 0 in one cycle.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   acc, acc_step;
  logic [WIDTH-1:0]   opnd;
  logic [2:0]         op_q;
  logic               neg_q;
  logic [WIDTH-1:0]   result_q;

  logic               a_neg, b_neg, neg_in, special;
  logic [WIDTH-1:0]   a_mag, b_mag, special_res, final_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] fix_in, fix_out;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC);
  assign result    = result_q;

  assign a_neg  = a[WIDTH-1] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
  assign b_neg  = b[WIDTH-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
  // The remainder follows the dividend; everything else follows the sign XOR.
  assign neg_in = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);

  mdu_negate #(.WIDTH(WIDTH)) u_neg_a (.neg(a_neg), .din(a), .dout(a_mag));
  mdu_negate #(.WIDTH(WIDTH)) u_neg_b (.neg(b_neg), .din(b), .dout(b_mag));

  assign mul_sum = acc[2*WIDTH:WIDTH] + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};

`ifdef MDU_DIV_EN
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

  logic             div_zero, div_ovf;
  logic [2*WIDTH:0] div_shift;
  logic [WIDTH:0]   div_trial;

  assign div_zero    = (b == '0);
  assign div_ovf     = (op == OP_DIV || op == OP_REM) && (a == MOST_NEG) && (b == '1);
  assign special     = op[2] && (div_zero || div_ovf);
  assign special_res = op[1] ? (div_zero ? a : '0) : (div_zero ? '1 : a);

  // Top bit of the trial difference is the borrow: set means the divisor did not fit.
  assign div_shift = {acc[2*WIDTH-1:0], 1'b0};
  assign div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, opnd};

  always_comb begin
    acc_step = div_shift;
    if (!op_q[2])
      acc_step = {1'b0, mul_sum, acc[WIDTH-1:1]};
    else if (!div_trial[WIDTH])
      acc_step = {div_trial, div_shift[WIDTH-1:1], 1'b1};
  end

  assign fix_in = op_q[2] ? {{WIDTH{1'b0}}, (op_q[1] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0])}
                          : acc_step[2*WIDTH-1:0];
`else
  assign special     = op[2];
  assign special_res = '0;
  assign acc_step    = {1'b0, mul_sum, acc[WIDTH-1:1]};
  assign fix_in      = acc_step[2*WIDTH-1:0];
`endif

  // Divide results sit in the low half so one wide negator covers every op.
  mdu_negate #(.WIDTH(2*WIDTH)) u_fix (.neg(neg_q), .din(fix_in), .dout(fix_out));

  assign final_res = (op_q[2] || op_q == OP_MUL) ? fix_out[WIDTH-1:0] : fix_out[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = special ? DONE : CALC;
        CALC:    if (cnt == LAST) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (!flush) begin
      if (state == IDLE && in_valid) begin
        op_q  <= op;
        neg_q <= neg_in;
        cnt   <= '0;
        acc   <= {{(WIDTH+1){1'b0}}, (op[2] ? a_mag : b_mag)};
        opnd  <= op[2] ? b_mag : a_mag;
        if (special) result_q <= special_res;
      end else if (state == CALC) begin
        acc <= acc_step;
        cnt <= cnt + CNT_W'(1);
        if (cnt == LAST) result_q <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vectors scored against an
// arithmetic model of results and handshake timing.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int WIDTH = 32;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int NEVER = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;

  typedef struct {
    int          acc_cyc;
    int          due_cyc;
    int          end_cyc;
    logic [31:0] res;
  } entry_t;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] lit;
  } vec_t;

  entry_t sb[$];
  vec_t   vecs[$];
  int     cyc = 0;
  int     n_vec = 0;
  int     n_fail = 0;
  int     c;

  mdu_iter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dv(input logic [31:0] x);
    return DIV_EN ? x : 32'h0;
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, ux, uy, p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (f)
      OP_MUL:    begin p = ux * uy; return p[31:0];  end
      OP_MULH:   begin p = sx * sy; return p[63:32]; end
      OP_MULHSU: begin p = sx * uy; return p[63:32]; end
      OP_MULHU:  begin p = ux * uy; return p[63:32]; end
      default: begin
        if (!DIV_EN) return 32'h0;
        if (y == 32'h0) return f[1] ? x : 32'hFFFF_FFFF;
        if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return f[1] ? 32'h0 : x;
        if (f == OP_DIV)  return $signed(x) / $signed(y);
        if (f == OP_DIVU) return x / y;
        if (f == OP_REM)  return $signed(x) % $signed(y);
        return x % y;
      end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (!f[2]) return WIDTH + 1;
    if (!DIV_EN) return 1;
    if (y == 32'h0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
    return WIDTH + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] lit, input bit pin, output int acc_at);
    entry_t e;
    in_valid = 1'b1;
    op = f;
    a = x;
    b = y;
    e.acc_cyc = cyc;
    e.due_cyc = cyc + latency(f, x, y);
    e.end_cyc = NEVER;
    e.res     = model(f, x, y);
    if (pin) checkOutput("model_pin", e.res, lit);
    sb.push_back(e);
    acc_at = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("[TB] FAIL wait_idle: operation still pending after 100 cycles (cycle %0d)", cyc);
      sb.delete();
    end
  endtask

  // Per-cycle compare against the scoreboard's expected handshake timing and result.
  always @(negedge clk) begin : chk
    logic er, eb, ev;
    while (sb.size() > 0 && cyc >= sb[0].end_cyc) void'(sb.pop_front());
    er = 1'b1;
    eb = 1'b0;
    ev = 1'b0;
    if (sb.size() > 0 && cyc > sb[0].acc_cyc) begin
      er = 1'b0;
      ev = (cyc >= sb[0].due_cyc);
      eb = !ev;
      if (ev) begin
        checkOutput("result", result, sb[0].res);
        if (out_ready) sb[0].end_cyc = cyc + 1;
      end
    end
    checkOutput("in_ready", {31'h0, in_ready}, {31'h0, er});
    checkOutput("busy", {31'h0, busy}, {31'h0, eb});
    checkOutput("out_valid", {31'h0, out_valid}, {31'h0, ev});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back('{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
    vecs.push_back('{OP_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000});
    vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{OP_MUL,    32'd7,         32'd6,         32'h0000_002A});
    vecs.push_back('{OP_MULH,   32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF});
    vecs.push_back('{OP_DIV,    32'hFFFF_FFF9, 32'd2,         dv(32'hFFFF_FFFD)});
    vecs.push_back('{OP_REM,    32'hFFFF_FFF9, 32'd2,         dv(32'hFFFF_FFFF)});
    vecs.push_back('{OP_DIVU,   32'h0000_1234, 32'd0,         dv(32'hFFFF_FFFF)});
    vecs.push_back('{OP_REMU,   32'h0000_1234, 32'd0,         dv(32'h0000_1234)});
    vecs.push_back('{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, dv(32'h8000_0000)});
    vecs.push_back('{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, dv(32'h0000_0000)});
    vecs.push_back('{OP_DIVU,   32'd100,       32'd7,         dv(32'h0000_000E)});
    vecs.push_back('{OP_REMU,   32'd100,       32'd7,         dv(32'h0000_0002)});
    vecs.push_back('{OP_DIV,    32'd7,         32'hFFFF_FFFE, dv(32'hFFFF_FFFD)});
    vecs.push_back('{OP_REM,    32'd7,         32'hFFFF_FFFE, dv(32'h0000_0001)});
    vecs.push_back('{OP_DIV,    32'h8000_0000, 32'd0,         dv(32'hFFFF_FFFF)});
    vecs.push_back('{OP_REM,    32'h8000_0000, 32'd0,         dv(32'h8000_0000)});

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("reset_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_result", result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].lit, 1'b1, c);
      waitIdle();
    end

    // Back-to-back: second accept lands exactly WIDTH+2 cycles after the first.
    applyStimulus(OP_MUL, 32'd3, 32'd4, 32'd12, 1'b1, c);
    repeat (WIDTH + 1) @(posedge clk);
    #1;
    applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1, c);
    waitIdle();

    applyStimulus(DIV_EN ? OP_DIV : OP_MUL, 32'd1000, 32'd7, 32'h0, 1'b0, c);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    sb[0].end_cyc = c + 11;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("flush_busy", {31'h0, busy}, 32'h0);
    repeat (40) @(posedge clk);
    #1;

    in_valid = 1'b1;
    op = OP_MUL;
    a = 32'd5;
    b = 32'd5;
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    checkOutput("flush_accept_in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("flush_accept_busy", {31'h0, busy}, 32'h0);
    repeat (40) @(posedge clk);
    #1;

    out_ready = 1'b0;
    applyStimulus(OP_MUL, 32'd3, 32'd5, 32'd15, 1'b1, c);
    repeat (WIDTH + 4) @(posedge clk);
    #1;
    checkOutput("stall_result", result, 32'd15);
    checkOutput("stall_out_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("stall_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    waitIdle();

    applyStimulus(DIV_EN ? OP_DIV : OP_MUL, 32'd123456, 32'd789, 32'h0, 1'b0, c);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb[0].end_cyc = c + 20;
    #1;
    checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_result", result, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
